inst_loader: RTL and testbench

Boot-time writer for the instruction memory. Accepts a byte stream from the UART receive path, assembles little-endian 32-bit words and drives the instruction-memory write port, so programs load without re-synthesising the `$readmemh` image. Holds the core in reset (`busy`) until an image has been received and its checksum verified. Sits between the UART byte receiver and the write side of the instruction RAM.

---
 rtl/inst_loader.sv | 128 ++++++++++++
 tb/tb_inst_loader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// inst_loader: boot-time instruction-memory writer.
// Assembles little-endian words from a UART byte stream (length, data, XOR
// checksum), writes them to instruction RAM and holds the core in reset
// until a verified image has been received.
module inst_loader #(
  parameter int unsigned DEPTH_WORDS = 32768,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        we,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS + 1);

  typedef enum logic [2:0] {
    S_LEN  = 3'd0,
    S_DATA = 3'd1,
    S_CSUM = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       cnt;
  logic [23:0]      sh;
  logic [31:0]      acc;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] n;

  logic             xfer_c;
  logic             last_c;
  logic [31:0]      word_c;
  logic [IDX_W-1:0] idx_inc_c;

  // Handshake and word assembly: the incoming byte becomes the top lane.
  assign xfer_c    = byte_valid && byte_ready;
  assign last_c    = xfer_c && (cnt == 2'd3);
  assign word_c    = {byte_data, sh};
  assign idx_inc_c = idx + 1'b1;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_LEN;
    else     state <= state_nxt;
  end

  // Next-state decode; every field completes on its 4th byte.
  always_comb begin
    state_nxt = state;
    case (state)
      S_LEN: begin
        if (last_c) begin
          if (word_c > 32'(DEPTH_WORDS)) state_nxt = S_ERR;
          else if (word_c == 32'd0)      state_nxt = S_CSUM;
          else                           state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (last_c && (idx_inc_c == n)) state_nxt = S_CSUM;
      end
      S_CSUM: begin
        if (last_c) state_nxt = (word_c == acc) ? S_DONE : S_ERR;
      end
      default: state_nxt = state;
    endcase
  end

  // Status outputs decoded from the state register.
  always_comb begin
    byte_ready = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    case (state)
      S_LEN, S_DATA, S_CSUM: byte_ready = 1'b1;
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      S_ERR:   error = 1'b1;
      default: byte_ready = 1'b0;
    endcase
  end

  // Datapath: byte lane counter, assembly, word count, write port and XOR.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= 2'd0;
      sh    <= 24'd0;
      acc   <= 32'd0;
      idx   <= '0;
      n     <= '0;
      we    <= 1'b0;
      waddr <= 32'd0;
      wdata <= 32'd0;
    end else begin
      we <= 1'b0;
      if (xfer_c) begin
        cnt <= cnt + 2'd1;
        sh  <= word_c[31:8];
      end
      if (last_c) begin
        case (state)
          S_LEN:  n <= IDX_W'(word_c);
          S_DATA: begin
            we    <= 1'b1;
            waddr <= BASE_ADDR + (32'(idx) << 2);
            wdata <= word_c;
            acc   <= acc ^ word_c;
            idx   <= idx_inc_c;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Testbench for inst_loader: per-cycle vector table for a back-to-back image,
// plus directed sequences for gaps, bad checksum, empty/oversize images,
// mid-load reset and stalled bytes after completion.
module tb_inst_loader;

  localparam int unsigned DEPTH = 32768;

  logic        clk = 1'b0;
  logic        rst;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        error;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [63:0] wq[$];

  typedef struct {
    logic        v;
    logic [7:0]  b;
    logic        ready;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        busy;
    logic        done;
    logic        err;
  } vec_t;

  vec_t tv[19];

  inst_loader #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0)) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  // Record every write strobe seen between edges.
  always @(negedge clk) begin
    if (we) wq.push_back({waddr, wdata});
  end

  task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [68:0] pack(input logic r, input logic w, input logic [31:0] a,
                                       input logic [31:0] d, input logic bz, input logic dn,
                                       input logic er);
    return {r, w, a, d, bz, dn, er};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    byte_valid = 1'b1;
    byte_data  = b;
    @(posedge clk); #1;
    byte_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] t;
      t = w >> (8 * k);
      send_byte(t[7:0], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_flags(input string name, input logic r, input logic bz,
                           input logic dn, input logic er);
    chk(name, 69'({byte_ready, busy, done, error}), 69'({r, bz, dn, er}));
  endtask

  initial begin
    logic [68:0] e;
    rst = 1'b1;
    byte_valid = 1'b0;
    byte_data = 8'h00;

    // Back-to-back N=2 image, then three stalled bytes after DONE.
    tv[0]  = '{1'b1, 8'h02, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0};
    tv[1]  = '{1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0};
    tv[2]  = '{1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0};
    tv[3]  = '{1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0};
    tv[4]  = '{1'b1, 8'h13, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0};
    tv[5]  = '{1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0};
    tv[6]  = '{1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0};
    tv[7]  = '{1'b1, 8'h00, 1'b1, 1'b1, 32'h0, 32'h13,       1'b1, 1'b0, 1'b0};
    tv[8]  = '{1'b1, 8'h93, 1'b1, 1'b0, 32'h0, 32'h13,       1'b1, 1'b0, 1'b0};
    tv[9]  = '{1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h13,       1'b1, 1'b0, 1'b0};
    tv[10] = '{1'b1, 8'h10, 1'b1, 1'b0, 32'h0, 32'h13,       1'b1, 1'b0, 1'b0};
    tv[11] = '{1'b1, 8'h00, 1'b1, 1'b1, 32'h4, 32'h0010_0093, 1'b1, 1'b0, 1'b0};
    tv[12] = '{1'b1, 8'h80, 1'b1, 1'b0, 32'h4, 32'h0010_0093, 1'b1, 1'b0, 1'b0};
    tv[13] = '{1'b1, 8'h00, 1'b1, 1'b0, 32'h4, 32'h0010_0093, 1'b1, 1'b0, 1'b0};
    tv[14] = '{1'b1, 8'h10, 1'b1, 1'b0, 32'h4, 32'h0010_0093, 1'b1, 1'b0, 1'b0};
    tv[15] = '{1'b1, 8'h00, 1'b0, 1'b0, 32'h4, 32'h0010_0093, 1'b0, 1'b1, 1'b0};
    tv[16] = '{1'b1, 8'hFF, 1'b0, 1'b0, 32'h4, 32'h0010_0093, 1'b0, 1'b1, 1'b0};
    tv[17] = '{1'b1, 8'hFF, 1'b0, 1'b0, 32'h4, 32'h0010_0093, 1'b0, 1'b1, 1'b0};
    tv[18] = '{1'b1, 8'hFF, 1'b0, 1'b0, 32'h4, 32'h0010_0093, 1'b0, 1'b1, 1'b0};

    // Reset state.
    @(posedge clk); #1;
    chk("reset", {byte_ready, we, waddr, wdata, busy, done, error},
        pack(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0));
    rst = 1'b0;

    // Table: one output check after each clock edge.
    for (int i = 0; i < 19; i++) begin
      byte_valid = tv[i].v;
      byte_data  = tv[i].b;
      @(posedge clk); #1;
      e = pack(tv[i].ready, tv[i].we, tv[i].addr, tv[i].data, tv[i].busy, tv[i].done, tv[i].err);
      chk($sformatf("vec%0d", i), {byte_ready, we, waddr, wdata, busy, done, error}, e);
    end
    byte_valid = 1'b0;
    idle(2);
    chk("b2b_nwrites", 69'(wq.size()), 69'd2);
    chk_flags("after_done_stall", 1'b0, 1'b0, 1'b1, 1'b0);

    // Same image with random idle gaps.
    do_reset();
    wq.delete();
    send_word(32'd2, 5);
    send_word(32'h0000_0013, 5);
    send_word(32'h0010_0093, 5);
    send_word(32'h0010_0080, 5);
    idle(2);
    chk("gap_nwrites", 69'(wq.size()), 69'd2);
    if (wq.size() == 2) begin
      chk("gap_w0", 69'(wq[0]), 69'({32'h0, 32'h0000_0013}));
      chk("gap_w1", 69'(wq[1]), 69'({32'h4, 32'h0010_0093}));
    end
    chk_flags("gap_flags", 1'b0, 1'b0, 1'b1, 1'b0);

    // Checksum mismatch.
    do_reset();
    wq.delete();
    send_word(32'd1, 0);
    send_word(32'hDEAD_BEEF, 0);
    send_word(32'hDEAD_BEEE, 0);
    idle(2);
    chk("badcs_nwrites", 69'(wq.size()), 69'd1);
    if (wq.size() == 1)
      chk("badcs_w0", 69'(wq[0]), 69'({32'h0, 32'hDEAD_BEEF}));
    chk_flags("badcs_flags", 1'b0, 1'b1, 1'b0, 1'b1);

    // Empty image.
    do_reset();
    wq.delete();
    send_word(32'd0, 0);
    send_word(32'd0, 0);
    idle(2);
    chk("empty_nwrites", 69'(wq.size()), 69'd0);
    chk_flags("empty_flags", 1'b0, 1'b0, 1'b1, 1'b0);

    // Oversize length: error right after the 4th length byte.
    do_reset();
    wq.delete();
    send_word(32'(DEPTH + 1), 0);
    chk_flags("oversize_flags", 1'b0, 1'b1, 1'b0, 1'b1);
    idle(4);
    chk("oversize_nwrites", 69'(wq.size()), 69'd0);

    // Reset mid-word, then a full 3-word image.
    do_reset();
    wq.delete();
    send_word(32'd3, 0);
    send_word(32'h1111_1111, 0);
    send_byte(8'h22, 0);
    send_byte(8'h22, 0);
    rst = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'h22;
    @(posedge clk); #1;
    rst = 1'b0;
    byte_valid = 1'b0;
    chk_flags("midrst_flags", 1'b1, 1'b1, 1'b0, 1'b0);
    idle(3);
    chk("midrst_nwrites", 69'(wq.size()), 69'd1);
    wq.delete();
    send_word(32'd3, 2);
    send_word(32'h1111_1111, 2);
    send_word(32'h2222_2222, 2);
    send_word(32'h4444_4444, 2);
    send_word(32'h7777_7777, 2);
    idle(2);
    chk("reload_nwrites", 69'(wq.size()), 69'd3);
    if (wq.size() == 3) begin
      chk("reload_w0", 69'(wq[0]), 69'({32'h0, 32'h1111_1111}));
      chk("reload_w1", 69'(wq[1]), 69'({32'h4, 32'h2222_2222}));
      chk("reload_w2", 69'(wq[2]), 69'({32'h8, 32'h4444_4444}));
    end
    chk_flags("reload_flags", 1'b0, 1'b0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
